// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares one data-memory port between the pipeline MEM stage and a
//            loader/debug port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_BYTES    = 36,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    output logic              pipe_fault,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    // Comparing against the last word address avoids the wrap that addr+3
    // would suffer near the top of the address space.
    localparam logic [ADDR_W-1:0] C_LAST_WORD    = ADDR_W'(MEM_BYTES - 4);
    localparam logic [3:0]        C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        LD_IDLE = 1'b0,
        LD_ACK  = 1'b1
    } ld_state_t;

    ld_state_t         r_state;
    logic [3:0]        r_starve_cnt;
    logic              r_ld_ack;
    logic              r_ld_err;
    logic [DATA_W-1:0] r_ld_rdata;
    logic              r_pipe_fault;

    logic w_ld_elig;
    logic w_owner;
    logic w_pipe_legal;
    logic w_ld_legal;

    function automatic logic is_legal(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= C_LAST_WORD);
    endfunction

    assign w_pipe_legal = is_legal(pipe_addr);
    assign w_ld_legal   = is_legal(ld_addr);
    assign w_ld_elig    = ld_req && (r_state == LD_IDLE);
    assign w_owner      = !reset && w_ld_elig &&
                          (!pipe_req || (r_starve_cnt == C_STARVE_LIMIT));

    assign owner      = w_owner;
    assign mem_addr   = w_owner ? ld_addr  : pipe_addr;
    assign mem_wdata  = w_owner ? ld_wdata : pipe_wdata;
    assign mem_we     = !reset && (w_owner ? (ld_we && w_ld_legal)
                                           : (pipe_req && pipe_we && w_pipe_legal));
    assign pipe_rdata = (!w_owner && w_pipe_legal) ? mem_rdata : '0;
    assign pipe_stall = pipe_req && w_owner;
    assign pipe_fault = r_pipe_fault;
    assign ld_ack     = r_ld_ack;
    assign ld_err     = r_ld_err;
    assign ld_rdata   = r_ld_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LD_IDLE;
            r_starve_cnt <= '0;
            r_ld_ack     <= 1'b0;
            r_ld_err     <= 1'b0;
            r_ld_rdata   <= '0;
            r_pipe_fault <= 1'b0;
        end else begin
            if (pipe_req && !w_owner && !w_pipe_legal) begin
                r_pipe_fault <= 1'b1;
            end
            case (r_state)
                LD_IDLE: begin
                    r_ld_ack <= 1'b0;
                    if (w_owner) begin
                        r_ld_rdata   <= w_ld_legal ? mem_rdata : '0;
                        r_ld_err     <= !w_ld_legal;
                        r_starve_cnt <= '0;
                        r_ld_ack     <= 1'b1;
                        r_state      <= LD_ACK;
                    end else if (w_ld_elig && (r_starve_cnt != C_STARVE_LIMIT)) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                // A still-high ld_req here is a new transaction, eligible next cycle.
                LD_ACK: begin
                    r_ld_ack <= 1'b0;
                    r_state  <= LD_IDLE;
                end
                default: begin
                    r_ld_ack <= 1'b0;
                    r_state  <= LD_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed self-checking bench for dmem_port_arbiter with a
//            behavioural word memory and a loader-response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_req, pipe_we;
    logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
    logic        pipe_stall, pipe_fault;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata, ld_rdata;
    logic        ld_ack, ld_err;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner;

    int total  = 0;
    int passed = 0;
    int we_pulses = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:8];
    logic [31:0] snap [0:8];

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_req   (pipe_req),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_rdata (pipe_rdata),
        .pipe_stall (pipe_stall),
        .pipe_fault (pipe_fault),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ack     (ld_ack),
        .ld_rdata   (ld_rdata),
        .ld_err     (ld_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .owner      (owner)
    );

    // Combinational-read memory of 36 bytes; out-of-range reads return 0.
    assign mem_rdata = (mem_addr < 32'd36) ? mem[mem_addr[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            we_pulses <= we_pulses + 1;
            if (mem_addr < 32'd36) mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic loader_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        logic got;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        ld_we = we; ld_addr = addr; ld_wdata = wdata; ld_req = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            next_cycle();
            if (ld_ack) begin
                got = 1'b1;
                ld_req = 1'b0;
                e = sb.pop_front();
                chk("ld_rdata", ld_rdata, e.rdata);
                chk("ld_err", ld_err, e.err);
            end
        end
        ld_req = 1'b0;
        chk("ld_ack_seen", got, 1'b1);
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 9; i++) mem[i] = 32'h0;
        mem[0] = 32'h1400_0000;
        reset = 1'b1;
        pipe_req = 0; pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        repeat (2) next_cycle();
        reset = 1'b0;
        #2;
        chk("rst_owner", owner, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_stall", pipe_stall, 1'b0);
        chk("rst_ld_ack", ld_ack, 1'b0);
        chk("rst_ld_err", ld_err, 1'b0);
        chk("rst_ld_rdata", ld_rdata, 32'h0);
        chk("rst_fault", pipe_fault, 1'b0);
        next_cycle();

        // Pipeline store then load at address 8.
        pipe_req = 1; pipe_we = 1; pipe_addr = 32'd8; pipe_wdata = 32'hDEAD_BEEF;
        #2;
        chk("pst_stall", pipe_stall, 1'b0);
        chk("pst_mem_we", mem_we, 1'b1);
        next_cycle();
        pipe_we = 0;
        #2;
        chk("pld_stall", pipe_stall, 1'b0);
        chk("pld_rdata", pipe_rdata, 32'hDEAD_BEEF);
        next_cycle();
        pipe_req = 0;

        // Loader alone, held request: acks at t+1 and t+3.
        ld_req = 1; ld_we = 0; ld_addr = 32'd0;
        #2;
        chk("ldh_grant_t", owner, 1'b1);
        next_cycle();
        chk("ldh_ack_t1", ld_ack, 1'b1);
        chk("ldh_rdata_t1", ld_rdata, 32'h1400_0000);
        chk("ldh_err_t1", ld_err, 1'b0);
        chk("ldh_owner_t1", owner, 1'b0);
        next_cycle();
        chk("ldh_ack_t2", ld_ack, 1'b0);
        chk("ldh_grant_t2", owner, 1'b1);
        next_cycle();
        chk("ldh_ack_t3", ld_ack, 1'b1);
        ld_req = 0;
        next_cycle();

        // Starvation: pipeline holds the port, loader wins on cycle 4.
        pipe_req = 1; pipe_we = 0; pipe_addr = 32'd4;
        ld_req = 1; ld_we = 0; ld_addr = 32'd0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("stv_owner_c%0d", i), owner, 1'b0);
            chk($sformatf("stv_stall_c%0d", i), pipe_stall, 1'b0);
            next_cycle();
        end
        #2;
        chk("stv_owner_c4", owner, 1'b1);
        chk("stv_stall_c4", pipe_stall, 1'b1);
        next_cycle();
        chk("stv_ack_c5", ld_ack, 1'b1);
        chk("stv_owner_c5", owner, 1'b0);
        chk("stv_stall_c5", pipe_stall, 1'b0);
        ld_req = 0;
        next_cycle();
        pipe_req = 0;
        next_cycle();

        // Illegal loader writes must not touch memory.
        for (int i = 0; i < 9; i++) snap[i] = mem[i];
        begin
            int we_before;
            we_before = we_pulses;
            loader_txn(1'b1, 32'd33, 32'hAAAA_5555, 32'h0, 1'b1);
            loader_txn(1'b1, 32'd36, 32'h5555_AAAA, 32'h0, 1'b1);
            chk("ill_we_pulses", 64'(we_pulses - we_before), 64'd0);
        end
        for (int i = 0; i < 9; i++) chk($sformatf("ill_mem%0d", i), mem[i], snap[i]);

        // Legal loader traffic, including the last word (addr 32).
        loader_txn(1'b0, 32'd8, 32'h0, 32'hDEAD_BEEF, 1'b0);
        loader_txn(1'b1, 32'd32, 32'h1234_5678, 32'h0, 1'b0);
        loader_txn(1'b0, 32'd32, 32'h0, 32'h1234_5678, 1'b0);

        // Misaligned pipeline store: suppressed, sticky fault.
        pipe_req = 1; pipe_we = 1; pipe_addr = 32'd34; pipe_wdata = 32'hCAFE_F00D;
        #2;
        chk("pf_mem_we", mem_we, 1'b0);
        chk("pf_before_edge", pipe_fault, 1'b0);
        next_cycle();
        chk("pf_after_edge", pipe_fault, 1'b1);
        pipe_req = 0; pipe_we = 0; pipe_addr = 32'd0;
        repeat (3) next_cycle();
        chk("pf_sticky", pipe_fault, 1'b1);
        reset = 1'b1;
        #1;
        chk("pf_reset_clr", pipe_fault, 1'b0);
        reset = 1'b0;
        next_cycle();

        // Reset pulse while in LD_ACK.
        ld_req = 1; ld_we = 0; ld_addr = 32'd4;
        #2;
        chk("rla_grant", owner, 1'b1);
        next_cycle();
        chk("rla_ack", ld_ack, 1'b1);
        reset = 1'b1;
        #1;
        chk("rla_ack_drop", ld_ack, 1'b0);
        chk("rla_mem_we", mem_we, 1'b0);
        chk("rla_stall", pipe_stall, 1'b0);
        reset = 1'b0;
        #1;
        chk("rla_idle_regrant", owner, 1'b1);
        next_cycle();
        chk("rla_ack_after", ld_ack, 1'b1);
        ld_req = 0;
        next_cycle();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the pipeline MEM stage and a loader/debug port (test loader, memory dump).
- Sits between the MEM-stage signals, the loader, and the data memory's Write_Enable/Address/Write_Data/Read_Data.
- The pipeline has priority. A starvation counter guarantees the loader forward progress.
- Out-of-range and misaligned accesses are blocked and reported.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (one word = 4 bytes).
- MEM_BYTES, 36, byte depth of the attached data memory.
- STARVE_LIMIT, 4, consecutive loader denials after which the loader wins one cycle (1..15).

Ports:
- clk  in  1  clock; all state on posedge
- reset  in  1  asynchronous, active-high reset
- pipe_req  in  1  MEM stage wants the memory this cycle (load or store)
- pipe_we  in  1  MEM stage store
- pipe_addr  in  ADDR_W  MEM stage byte address
- pipe_wdata  in  DATA_W  store data
- pipe_rdata  out  DATA_W  load data (combinational)
- pipe_stall  out  1  pipeline must hold the MEM stage this cycle
- pipe_fault  out  1  sticky: pipeline issued an illegal access
- ld_req  in  1  loader request; held until ld_ack
- ld_we  in  1  loader write
- ld_addr  in  ADDR_W  loader byte address
- ld_wdata  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle completion pulse
- ld_rdata  out  DATA_W  registered loader read data, valid with ld_ack
- ld_err  out  1  valid with ld_ack: access was illegal and suppressed
- mem_we  out  1  to memory Write_Enable
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Write_Data
- mem_rdata  in  DATA_W  from memory Read_Data (combinational read)
- owner  out  1  0 = pipeline owns the port this cycle, 1 = loader

Behaviour:
- Legal access: addr[1:0]==0 and addr+3 <= MEM_BYTES-1. With defaults, legal word addresses are 0..32.
- Loader FSM states: LD_IDLE, LD_ACK.
  - ld_elig = ld_req and state==LD_IDLE.
- Grant rule, per cycle: owner = ld_elig and (!pipe_req or starve_cnt==STARVE_LIMIT). Otherwise the pipeline owns the port.
- Port mux:
  - mem_addr/mem_wdata come from the owner; when idle they follow the pipeline inputs.
  - mem_we = owner's we AND owner's req AND legal AND !reset.
  - Illegal writes never reach memory.
- Pipeline path:
  - pipe_rdata = mem_rdata when the pipeline owns the port and the access is legal, else 0.
  - pipe_stall = pipe_req and owner==1 (combinational). The MEM stage simply retries the next cycle.
  - Illegal pipeline access (owner 0): suppressed, pipe_fault set. pipe_fault clears only on reset.
- starve_cnt:
  - Increments when ld_elig and owner==0, saturating at STARVE_LIMIT.
  - Clears to 0 when the loader is granted.
  - Holds in LD_ACK.
- Loader grant cycle (LD_IDLE, owner==1):
  - Register ld_rdata <= mem_rdata (0 if illegal) and ld_err <= !legal.
  - Transition to LD_ACK.
- LD_ACK:
  - ld_ack=1 for exactly this cycle; the loader is not eligible.
  - Always returns to LD_IDLE.
  - A loader still holding ld_req in this cycle is presenting a new transaction, eligible from the next cycle. Back-to-back loader accesses therefore take at least 2 cycles each.
- Latency:
  - Pipeline: 0 cycles (same-cycle read, write at the clock edge).
  - Loader: ld_ack exactly 1 cycle after the grant.
- Simultaneous pipe_req and ld_req with starve_cnt < STARVE_LIMIT: pipeline wins; the loader waits.
- Reset (asynchronous, any time, including mid-transaction in LD_ACK):
  - state=LD_IDLE, starve_cnt=0, ld_ack=0, ld_err=0, ld_rdata=0, pipe_fault=0.
  - The pending ack is dropped; the loader must re-request.
  - While reset is high, mem_we=0 and pipe_stall=0.
- ld_we/ld_addr/ld_wdata must be stable while ld_req is high; otherwise behaviour is undefined.

Test Plan:
- Reset then idle: all outputs 0, owner=0, mem_we=0. Pulse reset during LD_ACK: ld_ack falls immediately and the state returns to LD_IDLE.
- Pipeline store 0xDEADBEEF to addr 8, then load addr 8 with no loader: pipe_stall=0 both cycles, pipe_rdata=0xDEADBEEF on the load cycle.
- Loader alone, read addr 0 holding 0x14000000: grant at cycle t, ld_ack=1 at t+1 with ld_rdata=0x14000000, ld_err=0. Held ld_req yields a second ack at t+3.
- Starvation, pipe_req held high continuously and ld_req raised at cycle 0:
  - Cycles 0-3: owner=0, starve_cnt climbs 1..4.
  - Cycle 4: owner=1, pipe_stall=1.
  - Cycle 5: ld_ack=1, pipeline resumes.
- Loader write to addr 33 (misaligned) and to addr 36 (out of range): mem_we stays 0, ld_ack with ld_err=1, memory unchanged.
- Pipeline store to addr 34: mem_we=0, pipe_fault rises next edge and stays 1 until reset.
